cordic_engine: RTL



---
 rtl/cordic_engine.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cordic_engine.sv
// -----------------------------------------------------------------------------
// cordic_engine
//   Iterative CORDIC core. Performs one micro-rotation per clock. A full
//   operation takes ITER iterations. Two modes are supported:
//     * rotation  : z is driven towards 0, so (x,y) is rotated by z_in.
//     * vectoring : y is driven towards 0, so x ends at the magnitude and
//                   z ends at the phase.
//   The CORDIC gain K (~1.64676) is left in x_out/y_out. GUARD extra MSBs
//   on the x/y path absorb that gain.
//
// Ports
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset, aborts any operation
//   start    : request; accepted only in IDLE or DONE
//   mode     : 0 = rotation, 1 = vectoring (captured with start)
//   x_in     : signed x operand, WIDTH bits
//   y_in     : signed y operand, WIDTH bits
//   z_in     : signed binary angle, 2^(WIDTH-1) == pi
//   busy     : high while iterating
//   done     : one-cycle pulse, results valid on x_out/y_out/z_out
//   x_out    : signed x result, WIDTH+GUARD bits, includes gain
//   y_out    : signed y result, WIDTH+GUARD bits, includes gain
//   z_out    : signed residual / accumulated angle, WIDTH bits
// -----------------------------------------------------------------------------
module cordic_engine #(
   parameter int WIDTH = 16,
   parameter int ITER  = 16,
   parameter int GUARD = 2
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic                           mode,
   input  logic signed [WIDTH-1:0]        x_in,
   input  logic signed [WIDTH-1:0]        y_in,
   input  logic signed [WIDTH-1:0]        z_in,
   output logic                           busy,
   output logic                           done,
   output logic signed [WIDTH+GUARD-1:0]  x_out,
   output logic signed [WIDTH+GUARD-1:0]  y_out,
   output logic signed [WIDTH-1:0]        z_out
);

   localparam int XW = WIDTH + GUARD;
   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   // Arctangent table entry: round(atan(2^-i) * 2^(WIDTH-1) / pi).
   // Evaluated at elaboration with 96 fractional bits of integer arithmetic
   // so no real-valued math is needed. atan(1) = pi/4 is exact, so entry 0
   // is simply 2^(WIDTH-3). For i >= 1 the Taylor series of atan(2^-i)
   // converges at least as fast as 4^-k, so 48 terms exhaust the precision.
   function automatic logic signed [WIDTH-1:0] atan_entry(input int i);
      logic [127:0] pi_q;
      logic [127:0] acc;
      logic [127:0] term;
      logic [127:0] num;
      int           sh;
      pi_q = 128'h3_243F6A88_85A308D3_13198A2E;
      if (i == 0) begin
         acc = 128'd1 << (WIDTH - 3);
         return acc[WIDTH-1:0];
      end
      acc = '0;
      for (int k = 0; k < 48; k++) begin
         sh = 96 - i * (2 * k + 1);
         if (sh >= 0) begin
            term = (128'd1 << sh) / 128'(2 * k + 1);
            if ((k % 2) == 0) acc = acc + term;
            else              acc = acc - term;
         end
      end
      num = ((acc << (WIDTH - 1)) + (pi_q >> 1)) / pi_q;
      return num[WIDTH-1:0];
   endfunction

   logic signed [WIDTH-1:0] atan_rom [ITER];

   for (genvar g = 0; g < ITER; g++) begin : g_rom
      localparam logic signed [WIDTH-1:0] ANGLE = atan_entry(g);
      assign atan_rom[g] = ANGLE;
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CW-1:0]        cnt;
   logic                 load;
   logic                 last;

   logic                 mode_w;
   logic signed [XW-1:0] x_w;
   logic signed [XW-1:0] y_w;
   logic signed [WIDTH-1:0] z_w;

   logic signed [XW-1:0] x_sh;
   logic signed [XW-1:0] y_sh;
   logic signed [XW-1:0] x_rot;
   logic signed [XW-1:0] y_rot;
   logic signed [WIDTH-1:0] z_rot;
   logic                 d_pos;

   // ---- control: next state -------------------------------------------------
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               load      = 1'b1;
            end
         end
         RUN: begin
            if (cnt == CW'(ITER - 1)) begin
               state_nxt = DONE;
               last      = 1'b1;
            end
         end
         DONE: begin
            // A start here chains straight into the next operation while
            // done still pulses for the finished one.
            if (start) begin
               state_nxt = RUN;
               load      = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- micro-rotation: direction and shift-add -----------------------------
   always_comb begin
      x_sh  = x_w >>> cnt;
      y_sh  = y_w >>> cnt;
      d_pos = mode_w ? y_w[XW-1] : ~z_w[WIDTH-1];
      if (d_pos) begin
         x_rot = x_w - y_sh;
         y_rot = y_w + x_sh;
         z_rot = z_w - atan_rom[cnt];
      end else begin
         x_rot = x_w + y_sh;
         y_rot = y_w - x_sh;
         z_rot = z_w + atan_rom[cnt];
      end
   end

   // ---- working registers ---------------------------------------------------
   always_ff @(posedge clock) begin
      if (load) begin
         x_w    <= {{GUARD{x_in[WIDTH-1]}}, x_in};
         y_w    <= {{GUARD{y_in[WIDTH-1]}}, y_in};
         z_w    <= z_in;
         mode_w <= mode;
      end else if (state == RUN) begin
         x_w    <= x_rot;
         y_w    <= y_rot;
         z_w    <= z_rot;
      end
   end

   // ---- state, counter, handshake and result registers ----------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         x_out <= '0;
         y_out <= '0;
         z_out <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == RUN);
         done  <= (state_nxt == DONE);
         if (load)               cnt <= '0;
         else if (state == RUN)  cnt <= cnt + CW'(1);
         // Results are captured from the final rotation so they are
         // present during DONE and held untouched through the next RUN.
         if (last) begin
            x_out <= x_rot;
            y_out <= y_rot;
            z_out <= z_rot;
         end
      end
   end

endmodule
